// File: rtl/ghrd_rst_pkg.sv
// ghrd_rst_pkg
// Shared definitions for the GHRD fabric reset sequencer:
//   - state_t / S_INIT, S_HOLD, S_RUN : sequencer FSM encodings (3 is illegal)
//   - cause_t / CAUSE_*               : last_cause encodings
//   - RESET_COUNT_W                   : width of the saturating reset-event counter
//   - sat_inc()                       : saturating increment for that counter
package ghrd_rst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_INIT = 2'd0;
  localparam state_t S_HOLD = 2'd1;
  localparam state_t S_RUN  = 2'd2;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_INIT   = 2'd0;
  localparam cause_t CAUSE_PLL    = 2'd1;
  localparam cause_t CAUSE_BUTTON = 2'd2;
  localparam cause_t CAUSE_SW     = 2'd3;

  localparam int RESET_COUNT_W = 8;

  // The event counter sticks at all-ones so software can tell "many" from a
  // wrapped small number.
  function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// rst_debounce
// Synchronizes a raw, bouncy, active-low push-button and emits exactly one
// single-cycle press pulse once the synchronized level has been low for
// DEBOUNCE_CYCLES consecutive cycles. Pin-to-pulse latency is
// SYNC_STAGES + DEBOUNCE_CYCLES cycles; holding the button longer produces no
// further pulses until it has been released.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   pin_n    in   raw button pin, active-low, asynchronous
//   press    out  registered single-cycle press pulse
module rst_debounce #(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   button_s;
  logic [DW-1:0]          cnt;

  assign button_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; resets to the released (high) level so a reset never
  // looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n};
    end
  end

  // Low-time counter. It stops one past the firing value, so the pulse is
  // produced only on the single cycle the counter steps from
  // DEBOUNCE_CYCLES-1 onwards; any high sample restarts the measurement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (button_s) begin
        cnt <= '0;
      end else if (cnt != DW'(DEBOUNCE_CYCLES)) begin
        cnt   <= cnt + DW'(1);
        press <= (cnt == DW'(DEBOUNCE_CYCLES - 1));
      end
    end
  end

endmodule

// File: rtl/ghrd_reset_sequencer.sv
// ghrd_reset_sequencer
// Fabric-side reset sequencer driving the HPS platform subsystem reset
// (qsys_top reset_reset_n). After device init completes and the PLL locks, the
// subsystem is held in reset for HOLD_CYCLES and then released. A debounced
// button press, a software request or PLL loss re-issues the reset.
//
// Optional build macro: RSTSEQ_HEARTBEAT_EN adds a 1 Hz heartbeat output that
// toggles only while the subsystem is running.
//
// Ports:
//   clk_100_clk    in   system clock
//   reset_reset_n  in   synchronous active-low block reset
//   ninit_done     in   device init not done (async, active-high)
//   pll_locked     in   fabric PLL lock (async)
//   button_n       in   raw board push-button (async, active-low)
//   sw_reset_req   in   single-cycle software reset request (synchronous)
//   sys_reset_n    out  registered active-low subsystem reset
//   seq_state      out  current FSM state
//   last_cause     out  cause of the most recent reset
//   reset_count    out  saturating count of post-run reset events
//   heartbeat      out  1 Hz heartbeat (RSTSEQ_HEARTBEAT_EN only)
module ghrd_reset_sequencer
  import ghrd_rst_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100000000,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int CNT_W           = 24
) (
  input  logic                     clk_100_clk,
  input  logic                     reset_reset_n,
  input  logic                     ninit_done,
  input  logic                     pll_locked,
  input  logic                     button_n,
  input  logic                     sw_reset_req,
  output logic                     sys_reset_n,
  output logic [1:0]               seq_state,
  output logic [1:0]               last_cause,
  output logic [RESET_COUNT_W-1:0] reset_count
`ifdef RSTSEQ_HEARTBEAT_EN
  ,
  output logic                     heartbeat
`endif
);

  logic [SYNC_STAGES-1:0] ninit_sync_q;
  logic [SYNC_STAGES-1:0] pll_sync_q;
  logic                   ninit_done_s;
  logic                   pll_locked_s;
  logic                   press;
  state_t                 state;
  logic [CNT_W-1:0]       hold_cnt;

  assign ninit_done_s = ninit_sync_q[SYNC_STAGES-1];
  assign pll_locked_s = pll_sync_q[SYNC_STAGES-1];
  assign seq_state    = state;

  // Init-done and PLL-lock synchronizers. Reset values are the "not ready"
  // levels so the FSM cannot leave S_INIT until real status has propagated.
  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      ninit_sync_q <= '1;
      pll_sync_q   <= '0;
    end else begin
      ninit_sync_q <= {ninit_sync_q[SYNC_STAGES-2:0], ninit_done};
      pll_sync_q   <= {pll_sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  rst_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk   (clk_100_clk),
    .rst_n (reset_reset_n),
    .pin_n (button_n),
    .press (press)
  );

  // Sequencer FSM. sys_reset_n is registered alongside the state so it falls
  // on the edge the state leaves S_RUN and rises on the edge it enters S_RUN.
  // A press or software request during S_HOLD restarts the hold interval and
  // records the cause without counting a new event; only resets issued from
  // S_RUN (other than init loss) are counted.
  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      state       <= S_INIT;
      sys_reset_n <= 1'b0;
      last_cause  <= CAUSE_INIT;
      reset_count <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          sys_reset_n <= 1'b0;
          if (!ninit_done_s && pll_locked_s) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end

        S_HOLD: begin
          sys_reset_n <= 1'b0;
          if (ninit_done_s || !pll_locked_s) begin
            state <= S_INIT;
          end else if (press || sw_reset_req) begin
            hold_cnt   <= '0;
            last_cause <= press ? CAUSE_BUTTON : CAUSE_SW;
          end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state       <= S_RUN;
            sys_reset_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          sys_reset_n <= 1'b1;
          if (ninit_done_s) begin
            state       <= S_INIT;
            sys_reset_n <= 1'b0;
            last_cause  <= CAUSE_INIT;
          end else if (!pll_locked_s) begin
            state       <= S_INIT;
            sys_reset_n <= 1'b0;
            last_cause  <= CAUSE_PLL;
            reset_count <= sat_inc(reset_count);
          end else if (press || sw_reset_req) begin
            state       <= S_HOLD;
            sys_reset_n <= 1'b0;
            hold_cnt    <= '0;
            last_cause  <= press ? CAUSE_BUTTON : CAUSE_SW;
            reset_count <= sat_inc(reset_count);
          end
        end

        default: begin
          state       <= S_INIT;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

`ifdef RSTSEQ_HEARTBEAT_EN
  localparam int HB_HALF = CLK_FREQ_HZ / 2;

  logic [31:0] hb_cnt;

  // Heartbeat toggles every half second of clock while running and is parked
  // low with its counter cleared in every other state.
  always_ff @(posedge clk_100_clk) begin
    if (!reset_reset_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (state != S_RUN) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == 32'(HB_HALF - 1)) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ghrd_reset_sequencer.sv
// tb_ghrd_reset_sequencer
// Scoreboard bench for ghrd_reset_sequencer. Each issued reset event pushes
// its expected release (cycle, cause, count) into a queue; a monitor pops and
// compares whenever sys_reset_n rises. Build with RSTSEQ_HEARTBEAT_EN to also
// exercise the heartbeat.
module tb_ghrd_reset_sequencer;

  localparam int SYNC  = 2;
  localparam int DEB   = 8;
  localparam int HOLD  = 16;
  localparam int CLKHZ = 20;

  // An asynchronous pin changed just after edge N is acted on by the FSM at
  // edge N + SYNC + 1; a button press needs DEB more cycles of low level.
  localparam int ASYNC_EDGE = SYNC + 1;
  localparam int PRESS_EDGE = SYNC + DEB + 1;

  localparam int EV_SW   = 0;
  localparam int EV_BTN  = 1;
  localparam int EV_BOTH = 2;
  localparam int EV_PLL  = 3;
  localparam int EV_INIT = 4;

  logic       clk_100_clk = 1'b0;
  logic       reset_reset_n;
  logic       ninit_done;
  logic       pll_locked;
  logic       button_n;
  logic       sw_reset_req;
  logic       sys_reset_n;
  logic [1:0] seq_state;
  logic [1:0] last_cause;
  logic [7:0] reset_count;
`ifdef RSTSEQ_HEARTBEAT_EN
  logic       heartbeat;
`endif

  typedef struct {
    int rel_cyc;
    int cause;
    int count;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int m_count = 0;
  int m_cause = 0;
  int hold_entry = 0;
  logic prev_rn = 1'b0;
  logic [1:0] prev_state = 2'd0;

  ghrd_reset_sequencer #(
    .CLK_FREQ_HZ     (CLKHZ),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .CNT_W           (24)
  ) dut (
    .clk_100_clk   (clk_100_clk),
    .reset_reset_n (reset_reset_n),
    .ninit_done    (ninit_done),
    .pll_locked    (pll_locked),
    .button_n      (button_n),
    .sw_reset_req  (sw_reset_req),
    .sys_reset_n   (sys_reset_n),
    .seq_state     (seq_state),
    .last_cause    (last_cause),
    .reset_count   (reset_count)
`ifdef RSTSEQ_HEARTBEAT_EN
    ,
    .heartbeat     (heartbeat)
`endif
  );

  // Free-running clock and an edge counter used to timestamp events.
  always #5 clk_100_clk = ~clk_100_clk;

  always @(posedge clk_100_clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100_clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a reset event updates the recorded cause and, if it is
  // a counted event, bumps the count with saturation at 255.
  task automatic modelEvent(input int cause, input bit counted);
    m_cause = cause;
    if (counted && m_count < 255) m_count = m_count + 1;
  endtask

  task automatic expectRelease(input int rel, input int cause, input bit counted, input bit lat);
    exp_t e;
    modelEvent(cause, counted);
    e.rel_cyc = rel;
    e.cause   = m_cause;
    e.count   = m_count;
    e.lat     = lat;
    exp_q.push_back(e);
  endtask

  task automatic waitDrain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    checkOutput("release_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Issues one reset event from S_RUN and records the release it must cause.
  task automatic applyStimulus(input int kind, input int len);
    int n;
    n = cyc;
    case (kind)
      EV_SW: begin
        sw_reset_req = 1'b1;
        expectRelease(n + 1 + HOLD, 3, 1'b1, 1'b1);
        tick(1);
        sw_reset_req = 1'b0;
      end
      EV_BTN: begin
        button_n = 1'b0;
        expectRelease(n + PRESS_EDGE + HOLD, 2, 1'b1, 1'b1);
        tick(len);
        button_n = 1'b1;
        tick(SYNC + 2);
      end
      EV_BOTH: begin
        button_n = 1'b0;
        expectRelease(n + PRESS_EDGE + HOLD, 2, 1'b1, 1'b1);
        tick(SYNC + DEB);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(len - SYNC - DEB - 1);
        button_n = 1'b1;
        tick(SYNC + 2);
      end
      EV_PLL: begin
        pll_locked = 1'b0;
        expectRelease(n + len + ASYNC_EDGE + HOLD, 1, 1'b1, 1'b1);
        tick(ASYNC_EDGE);
        checkOutput("pll_loss_state", seq_state, 0);
        checkOutput("pll_loss_cause", last_cause, 1);
        tick(len - ASYNC_EDGE);
        pll_locked = 1'b1;
      end
      default: begin
        ninit_done = 1'b1;
        expectRelease(n + len + ASYNC_EDGE + HOLD, 0, 1'b0, 1'b1);
        tick(ASYNC_EDGE);
        checkOutput("init_loss_state", seq_state, 0);
        checkOutput("init_loss_cause", last_cause, 0);
        tick(len - ASYNC_EDGE);
        ninit_done = 1'b0;
      end
    endcase
  endtask

  // Monitor: every cycle sys_reset_n must be high exactly in S_RUN; each
  // rising edge of sys_reset_n is a release transaction checked against the
  // oldest expectation.
  always @(negedge clk_100_clk) begin
    if (cyc > 0) begin
      checkOutput("rst_vs_state", int'(sys_reset_n), int'(seq_state == 2'd2));
      if (seq_state == 2'd1 && prev_state != 2'd1) hold_entry = cyc;
      if (sys_reset_n && !prev_rn) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_release", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("release_cycle", cyc, mon_e.rel_cyc);
          checkOutput("release_cause", last_cause, mon_e.cause);
          checkOutput("release_count", reset_count, mon_e.count);
          if (mon_e.lat) checkOutput("hold_length", cyc - hold_entry, HOLD);
        end
      end
      prev_rn    = sys_reset_n;
      prev_state = seq_state;
    end
  end

  initial begin
    int n;
    int kind;
    int len;

    reset_reset_n = 1'b0;
    ninit_done    = 1'b1;
    pll_locked    = 1'b1;
    button_n      = 1'b1;
    sw_reset_req  = 1'b0;

    $display("[TB] power-up");
    tick(5);
    checkOutput("reset_sys_reset_n", sys_reset_n, 0);
    checkOutput("reset_seq_state", seq_state, 0);
    checkOutput("reset_last_cause", last_cause, 0);
    checkOutput("reset_count0", reset_count, 0);
`ifdef RSTSEQ_HEARTBEAT_EN
    checkOutput("reset_heartbeat", heartbeat, 0);
`endif
    reset_reset_n = 1'b1;
    tick(20);
    checkOutput("init_wait_state", seq_state, 0);
    ninit_done = 1'b0;
    n = cyc;
    expectRelease(n + ASYNC_EDGE + HOLD, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] button bounce");
    for (int i = 0; i < 10; i++) begin
      button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    button_n = 1'b1;
    tick(10);
    checkOutput("bounce_count", reset_count, 0);
    checkOutput("bounce_state", seq_state, 2);
    applyStimulus(EV_BTN, 40);
    waitDrain();

    $display("[TB] simultaneous press and software request");
    applyStimulus(EV_BOTH, 20);
    waitDrain();
    tick(3);
    applyStimulus(EV_SW, 0);
    waitDrain();

    $display("[TB] pll loss");
    tick(2);
    applyStimulus(EV_PLL, 5);
    waitDrain();

    $display("[TB] randomized events");
    for (int i = 0; i < 24; i++) begin
      tick($urandom_range(1, 4));
      kind = $urandom_range(0, 4);
      case (kind)
        EV_BTN:  len = $urandom_range(10, 30);
        EV_BOTH: len = $urandom_range(12, 30);
        EV_SW:   len = 0;
        default: len = $urandom_range(3, 8);
      endcase
      applyStimulus(kind, len);
      waitDrain();
    end

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(EV_SW, 0);
      waitDrain();
      tick($urandom_range(1, 3));
    end
    checkOutput("sat_count", reset_count, 255);

    $display("[TB] hold restart");
    sw_reset_req = 1'b1;
    modelEvent(3, 1'b1);
    tick(1);
    sw_reset_req = 1'b0;
    tick(10);
    sw_reset_req = 1'b1;
    expectRelease(cyc + 1 + HOLD, 3, 1'b0, 1'b0);
    tick(1);
    sw_reset_req = 1'b0;
    waitDrain();
    tick(2);
    sw_reset_req = 1'b1;
    modelEvent(3, 1'b1);
    tick(1);
    sw_reset_req = 1'b0;
    tick(2);
    button_n = 1'b0;
    expectRelease(cyc + PRESS_EDGE + HOLD, 2, 1'b0, 1'b0);
    tick(12);
    button_n = 1'b1;
    tick(SYNC + 2);
    waitDrain();
    checkOutput("restart_count", reset_count, 255);

    $display("[TB] mid-operation reset");
    tick(2);
    sw_reset_req = 1'b1;
    modelEvent(3, 1'b1);
    tick(1);
    sw_reset_req = 1'b0;
    tick(5);
    checkOutput("pre_reset_state", seq_state, 1);
    reset_reset_n = 1'b0;
    tick(1);
    checkOutput("mid_reset_sys_reset_n", sys_reset_n, 0);
    checkOutput("mid_reset_state", seq_state, 0);
    checkOutput("mid_reset_cause", last_cause, 0);
    checkOutput("mid_reset_count", reset_count, 0);
`ifdef RSTSEQ_HEARTBEAT_EN
    checkOutput("mid_reset_heartbeat", heartbeat, 0);
`endif
    m_count = 0;
    m_cause = 0;
    tick(2);
    reset_reset_n = 1'b1;
    expectRelease(cyc + ASYNC_EDGE + HOLD, 0, 1'b0, 1'b1);
    waitDrain();

`ifdef RSTSEQ_HEARTBEAT_EN
    $display("[TB] heartbeat");
    begin
      int t0;
      int guard;
      logic hb0;
      hb0 = heartbeat;
      guard = 0;
      while (heartbeat == hb0 && guard < 50) begin
        tick(1);
        guard++;
      end
      t0 = cyc;
      hb0 = heartbeat;
      guard = 0;
      while (heartbeat == hb0 && guard < 50) begin
        tick(1);
        guard++;
      end
      checkOutput("heartbeat_period", cyc - t0, CLKHZ / 2);
    end
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
